serial_comparator: RTL and testbench

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

---
 rtl/serial_comparator.sv | 115 +++++++++++
 tb/tb_serial_comparator.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_comparator.sv
// rtl/serial_comparator.sv - bit-serial MSB-first unsigned magnitude comparator with valid/ready handshakes
module serial_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       a_less_b,
  output logic                       a_equal_b,
  output logic                       a_greater_b,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic             r_le;
  logic             r_eq;
  logic [CW-1:0]    r_bit_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_lt;
  logic             r_equal;
  logic             r_gt;

  logic w_ai;
  logic w_bi;
  logic w_le_nxt;
  logic w_eq_nxt;
  logic w_last;

  // The shift registers present the current MSB; everything below it is still unexamined.
  assign w_ai     = r_sa[WIDTH-1];
  assign w_bi     = r_sb[WIDTH-1];
  assign w_le_nxt = r_le | (r_eq & ~w_ai & w_bi);
  assign w_eq_nxt = r_eq & ~(w_ai ^ w_bi);
  assign w_last   = (r_bit_count == CW'(WIDTH - 1)) || (EARLY_EXIT && !w_eq_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sa        <= '0;
      r_sb        <= '0;
      r_le        <= 1'b0;
      r_eq        <= 1'b1;
      r_bit_count <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_lt        <= 1'b0;
      r_equal     <= 1'b0;
      r_gt        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_sa        <= a;
            r_sb        <= b;
            r_le        <= 1'b0;
            r_eq        <= 1'b1;
            r_bit_count <= '0;
            r_in_ready  <= 1'b0;
            r_state     <= RUN;
          end else begin
            r_in_ready  <= 1'b1;
          end
        end
        RUN: begin
          r_sa        <= r_sa << 1;
          r_sb        <= r_sb << 1;
          r_le        <= w_le_nxt;
          r_eq        <= w_eq_nxt;
          r_bit_count <= r_bit_count + CW'(1);
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_lt        <= w_le_nxt;
            r_equal     <= w_eq_nxt;
            r_gt        <= ~w_le_nxt & ~w_eq_nxt;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // Result and count are frozen here until the consumer takes them.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_lt        <= 1'b0;
            r_equal     <= 1'b0;
            r_gt        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign a_less_b    = r_lt;
  assign a_equal_b   = r_equal;
  assign a_greater_b = r_gt;
  assign bit_count   = r_bit_count;

endmodule

// File: tb/tb_serial_comparator.sv
// tb/tb_serial_comparator.sv - directed self-checking bench for serial_comparator
module tb_serial_comparator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_valid_e = 1'b0;
  logic       out_ready = 1'b1, out_ready_e = 1'b1;
  logic [7:0] a = '0, b = '0, a_e = '0, b_e = '0;
  logic       in_ready, out_valid, a_less_b, a_equal_b, a_greater_b;
  logic       in_ready_e, out_valid_e, a_less_b_e, a_equal_b_e, a_greater_b_e;
  logic [3:0] bit_count, bit_count_e;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .a_less_b(a_less_b),
    .a_equal_b(a_equal_b), .a_greater_b(a_greater_b), .bit_count(bit_count));

  serial_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid_e), .in_ready(in_ready_e), .a(a_e), .b(b_e),
    .out_valid(out_valid_e), .out_ready(out_ready_e), .a_less_b(a_less_b_e),
    .a_equal_b(a_equal_b_e), .a_greater_b(a_greater_b_e), .bit_count(bit_count_e));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one operand pair, scrambles the inputs, and returns edges until out_valid.
  task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, output int lat);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    in_valid = 1'b1; a = aa; b = bb;
    tick();
    in_valid = 1'b0; a = ~aa; b = ~bb;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
  endtask

  task automatic run_op_e(input logic [7:0] aa, input logic [7:0] bb, output int lat);
    int n = 0;
    while (!in_ready_e && n < 20) begin tick(); n++; end
    in_valid_e = 1'b1; a_e = aa; b_e = bb;
    tick();
    in_valid_e = 1'b0; a_e = ~aa; b_e = ~bb;
    lat = 0;
    while (!out_valid_e && lat < 40) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if ({a_less_b, a_equal_b, a_greater_b} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {a_less_b, a_equal_b, a_greater_b}); end
    n_cmp++; if (bit_count !== 4'd0) begin n_fail++; $display("FAIL rst_bit_count: got %0d want 0", bit_count); end
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_equal();
    int lat;
    out_ready = 1'b1;
    run_op(8'h5A, 8'h5A, lat);
    n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL eq_latency: got %0d want 8", lat); end
    n_cmp++; if ({a_less_b, a_equal_b, a_greater_b} !== 3'b010) begin n_fail++; $display("FAIL eq_flags: got %b want 010", {a_less_b, a_equal_b, a_greater_b}); end
    n_cmp++; if (bit_count !== 4'd8) begin n_fail++; $display("FAIL eq_bit_count: got %0d want 8", bit_count); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL eq_release: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL eq_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_less_greater();
    int lat;
    run_op(8'h12, 8'h13, lat);
    n_cmp++; if ({a_less_b, a_equal_b, a_greater_b} !== 3'b100) begin n_fail++; $display("FAIL lt_flags: got %b want 100", {a_less_b, a_equal_b, a_greater_b}); end
    tick();
    run_op(8'h80, 8'h7F, lat);
    n_cmp++; if ({a_less_b, a_equal_b, a_greater_b} !== 3'b001) begin n_fail++; $display("FAIL gt_flags: got %b want 001", {a_less_b, a_equal_b, a_greater_b}); end
    n_cmp++; if (lat !== 8) begin n_fail++; $display("FAIL gt_latency: got %0d want 8", lat); end
    tick();
  endtask

  task automatic test_early_exit();
    int lat;
    out_ready_e = 1'b1;
    run_op_e(8'h00, 8'h80, lat);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL ee_latency: got %0d want 1", lat); end
    n_cmp++; if ({a_less_b_e, a_equal_b_e, a_greater_b_e} !== 3'b100) begin n_fail++; $display("FAIL ee_flags: got %b want 100", {a_less_b_e, a_equal_b_e, a_greater_b_e}); end
    n_cmp++; if (bit_count_e !== 4'd1) begin n_fail++; $display("FAIL ee_bit_count: got %0d want 1", bit_count_e); end
    tick();
    run_op_e(8'h40, 8'h00, lat);
    n_cmp++; if (lat !== 2 || a_greater_b_e !== 1'b1 || bit_count_e !== 4'd2) begin n_fail++; $display("FAIL ee_bit6: got lat %0d gt %b cnt %0d want 2 1 2", lat, a_greater_b_e, bit_count_e); end
    tick();
    run_op_e(8'h5A, 8'h5A, lat);
    n_cmp++; if (lat !== 8 || a_equal_b_e !== 1'b1 || bit_count_e !== 4'd8) begin n_fail++; $display("FAIL ee_equal: got lat %0d eq %b cnt %0d want 8 1 8", lat, a_equal_b_e, bit_count_e); end
    tick();
    run_op(8'h00, 8'h80, lat);
    n_cmp++; if (lat !== 8 || a_less_b !== 1'b1 || bit_count !== 4'd8) begin n_fail++; $display("FAIL noee_latency: got lat %0d lt %b cnt %0d want 8 1 8", lat, a_less_b, bit_count); end
    tick();
  endtask

  task automatic test_backpressure();
    int n = 0;
    out_ready = 1'b0;
    while (!in_ready && n < 20) begin tick(); n++; end
    in_valid = 1'b1; a = 8'h80; b = 8'h7F;
    tick();
    a = 8'h00; b = 8'hFF;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    n_cmp++; if (n !== 8) begin n_fail++; $display("FAIL bp_latency: got %0d want 8", n); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || {a_less_b, a_equal_b, a_greater_b} !== 3'b001 || bit_count !== 4'd8 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v%b f%b c%0d r%b want v1 f001 c8 r0", i, out_valid, {a_less_b, a_equal_b, a_greater_b}, bit_count, in_ready);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got v%b r%b want v0 r1", out_valid, in_ready); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'h00; b = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || bit_count !== 4'd0) begin n_fail++; $display("FAIL abort_state: got v%b r%b c%0d want v0 r0 c0", out_valid, in_ready, bit_count); end
    rst = 1'b0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      if (i < 9) tick();
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); end
    run_op(8'hFF, 8'h00, lat);
    n_cmp++; if (lat !== 8 || {a_less_b, a_equal_b, a_greater_b} !== 3'b001) begin n_fail++; $display("FAIL abort_next_op: got lat %0d f%b want 8 001", lat, {a_less_b, a_equal_b, a_greater_b}); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(8'h01, 8'h00, lat);
    n_cmp++; if (a_greater_b !== 1'b1 || bit_count !== 4'd8) begin n_fail++; $display("FAIL b2b_first: got gt%b c%0d want gt1 c8", a_greater_b, bit_count); end
    run_op(8'hFE, 8'hFF, lat);
    n_cmp++; if (lat !== 8 || a_less_b !== 1'b1 || a_greater_b !== 1'b0) begin n_fail++; $display("FAIL b2b_second: got lat %0d lt%b gt%b want 8 1 0", lat, a_less_b, a_greater_b); end
    tick();
  endtask

  initial begin
    test_reset();
    test_equal();
    test_less_greater();
    test_early_exit();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
